div_iterative: RTL and testbench
================================

Name: div_iterative

Overview:
Sequential signed 32-bit divider datapath and controller for the MultDiv unit. It accepts operands on a one-cycle start pulse and runs one restoring shift/subtract step per clock, driven by an internal iteration counter. It then returns the quotient with a one-cycle ready pulse. The ALU/pipeline stall logic consumes `busy` and `data_resultRDY`.

Parameters:
- WIDTH, 32, operand/quotient width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- ctrl_div  in  1  start pulse; operands sampled on the same edge
- data_operandA  in  WIDTH  dividend, two's complement
- data_operandB  in  WIDTH  divisor, two's complement
- data_result  out  WIDTH  quotient, truncated toward zero
- data_exception  out  1  divide-by-zero flag, valid while data_resultRDY=1
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high while an operation is in flight

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset mid-operation abandons the operation and produces no ready pulse.
- States:
  - IDLE: ctrl_div=1 -> LOAD.
  - LOAD (1 cycle): latch |A| and |B|, sign = A[W-1]^B[W-1], dz = (B==0); clear counter and remainder -> RUN.
  - RUN: one restoring step per cycle:
    - rem = {rem[W-2:0], q[W-1]}, q <<= 1.
    - If rem >= |B| then rem -= |B| and q[0] = 1.
    - Counter increments each step. When counter == WIDTH-1 -> DONE.
  - DONE (1 cycle): data_result = dz ? 0 : (sign ? -q : q); data_exception = dz; data_resultRDY = 1 -> IDLE.
- Latency: ctrl_div sampled at edge E0 => data_resultRDY is high for exactly the cycle following edge E0+WIDTH+2 (34 cycles for WIDTH=32). Divide-by-zero uses the same latency, with no early exit.
- busy = 1 in LOAD, RUN, DONE; busy = 0 in IDLE.
- data_result and data_exception hold their values after the pulse until the next DONE. They are not cleared by a new start.
- ctrl_div while busy: restarts. New operands are latched next edge, state goes to LOAD, and the prior operation is dropped with no ready pulse. ctrl_div coincident with DONE: the DONE pulse still fires, and the new operation starts in LOAD.
- Overflow: 0x80000000 / 0xFFFFFFFF -> result 0x80000000 (wraps), data_exception=0.
- Absolute values use WIDTH-bit two's-complement negation. |0x80000000| = 0x80000000 is interpreted unsigned, so the datapath magnitude is unsigned WIDTH bits. The remainder register is WIDTH+1 bits to absorb the compare.
- Remainder is internal only and not exported.
- Counter saturates at WIDTH-1, is cleared in LOAD, and holds in IDLE.

Decomposition:
- Shared package `multdiv_pkg`:
  - state enum: DIV_IDLE, DIV_LOAD, DIV_RUN, DIV_DONE
  - DIV_WIDTH = 32
  - DIV_CNT_W = 6
- One sub-module, `div_iter_counter`:
  - Ports: clk, reset (async active-low), clear, en, count[CNT_W-1:0], tc.
  - tc is high when count == WIDTH-1.
  - Built from T-flip-flop ripple-enable style consistent with existing MultDiv counters.
- Step logic (compare/subtract/shift) stays inline in `div_iterative`.

Test Plan:
- A=100, B=7, pulse ctrl_div -> 34 cycles later data_resultRDY=1 for one cycle, data_result=14, data_exception=0, busy falls the next cycle.
- A=-100 (0xFFFFFF9C), B=7 -> data_result=0xFFFFFFF2 (-14). Also A=-100, B=-7 -> data_result=14.
- A=5, B=0 -> at 34 cycles data_exception=1, data_result=0. Then A=6, B=3 -> data_exception=0, result=2.
- A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=0. Also A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF.
- Start A=1000, B=10. At cycle 10 pulse ctrl_div with A=81, B=9 -> exactly one ready pulse, 34 cycles after the second start, data_result=9.
- Start an operation, drive reset=0 asynchronously mid-RUN (not clock-aligned) -> all outputs 0 immediately, busy=0. Release reset -> no ready pulse appears; a fresh operation 42/6 returns 7.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the MultDiv unit: divider FSM states and default widths.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_LOAD = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_iterative_if.sv
// Start/operand/result bundle between the pipeline (master) and the divider (slave).
interface div_iterative_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_div, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_div, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter built as a chain of toggle stages; saturates at WIDTH-1.
module div_iter_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] toggle;

    assign tc = (count_q == CNT_W'(WIDTH - 1));

    // Each stage toggles only when every lower stage is 1 (ripple enable).
    assign toggle[0] = en & ~tc;

    generate
        for (genvar gi = 1; gi < CNT_W; gi++) begin : g_ripple
            assign toggle[gi] = toggle[gi-1] & count_q[gi-1];
        end
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_tff
            assign count_d[gi] = clear ? 1'b0 : (count_q[gi] ^ toggle[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/div_iterative.sv
// Sequential signed restoring divider: one shift/subtract step per clock, WIDTH+2 cycle latency.
module div_iterative
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic           clk,
    input logic           reset,
    div_iterative_if.slave bus
);

    div_state_e       state_q;
    div_state_e       state_d;

    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH-1:0] b_raw_q;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] b_abs_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH:0]   rem_sub;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH-1:0] result_q;
    logic             sign_q;
    logic             dz_q;
    logic             exc_q;
    logic             rdy_q;

    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             last_step;
    logic             busy;
    logic             cnt_clear;
    logic             cnt_en;

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .count (cnt),
        .tc    (tc)
    );

    assign last_step = tc && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start pulse in any state restarts from LOAD; DONE still reports its result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (bus.ctrl_div) state_d = DIV_LOAD;
            DIV_LOAD: state_d = bus.ctrl_div ? DIV_LOAD : DIV_RUN;
            DIV_RUN: begin
                if (bus.ctrl_div)   state_d = DIV_LOAD;
                else if (last_step) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = bus.ctrl_div ? DIV_LOAD : DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != DIV_IDLE);
        cnt_clear = (state_q == DIV_LOAD);
        cnt_en    = (state_q == DIV_RUN);
    end

    // Magnitudes are unsigned: |0x80..0| stays 0x80..0 and still divides correctly.
    assign a_abs = a_raw_q[WIDTH-1] ? -a_raw_q : a_raw_q;
    assign b_abs = b_raw_q[WIDTH-1] ? -b_raw_q : b_raw_q;

    always_comb begin
        rem_shift = {rem_q, q_q[WIDTH-1]};
        rem_sub   = rem_shift[WIDTH:0] - {1'b0, b_abs_q};
        if (rem_shift >= {2'b00, b_abs_q}) begin
            rem_d = rem_sub;
            q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift[WIDTH:0];
            q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_raw_q  <= '0;
            b_raw_q  <= '0;
            b_abs_q  <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            if (bus.ctrl_div) begin
                a_raw_q <= bus.data_operandA;
                b_raw_q <= bus.data_operandB;
            end
            case (state_q)
                DIV_LOAD: begin
                    q_q     <= a_abs;
                    b_abs_q <= b_abs;
                    rem_q   <= '0;
                    sign_q  <= a_raw_q[WIDTH-1] ^ b_raw_q[WIDTH-1];
                    dz_q    <= (b_raw_q == '0);
                end
                DIV_RUN: begin
                    q_q   <= q_d;
                    rem_q <= rem_d;
                end
                DIV_DONE: begin
                    result_q <= dz_q ? '0 : (sign_q ? -q_q : q_q);
                    exc_q    <= dz_q;
                end
                default: ;
            endcase
            rdy_q <= (state_q == DIV_DONE);
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy;

endmodule

// File: tb/tb_div_iterative.sv
// Directed-vector bench for div_iterative with a queue scoreboard checked by an independent monitor.
module tb_div_iterative;
    import multdiv_pkg::*;

    localparam int W   = DIV_WIDTH;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    div_iterative_if #(.WIDTH(W)) bus ();

    div_iterative #(
        .WIDTH (W),
        .CNT_W (DIV_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rdy: got pulse at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                $display("txn %s: res=%h exc=%b cycle=%0d", e.name, bus.data_result,
                         bus.data_exception, cyc);
                check({e.name, "_res"}, bus.data_result, e.res);
                check({e.name, "_exc"}, W'(bus.data_exception), W'(e.exc));
                check({e.name, "_lat"}, W'(cyc), W'(e.due));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic exc,
                         input string nm, input bit expect_done);
        exp_t e;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_div      = 1'b1;
        if (expect_done) begin
            e.res  = res;
            e.exc  = exc;
            e.due  = cyc + 1 + LAT;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.ctrl_div = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
        check({nm, "_busy_idle"}, W'(bus.busy), W'(1'b0));
    endtask

    initial begin
        bus.ctrl_div      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        repeat (3) @(negedge clk);
        check("reset_rdy",    W'(bus.data_resultRDY), W'(1'b0));
        check("reset_busy",   W'(bus.busy),           W'(1'b0));
        check("reset_result", bus.data_result,        W'(0));
        check("reset_exc",    W'(bus.data_exception), W'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, 32'd14, 1'b0, "100/7", 1'b1);
        repeat (3) @(negedge clk);
        check("busy_run", W'(bus.busy), W'(1'b1));
        drain("100/7");

        issue(32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, "-100/7",  1'b1); drain("-100/7");
        issue(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, "-100/-7", 1'b1); drain("-100/-7");
        issue(32'd5,        32'd0,        32'd0,        1'b1, "5/0",     1'b1); drain("5/0");
        issue(32'd6,        32'd3,        32'd2,        1'b0, "6/3",     1'b1); drain("6/3");
        issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "min/-1",  1'b1); drain("min/-1");
        issue(32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, "max/1",   1'b1); drain("max/1");
        issue(32'd7,        32'd100,      32'd0,        1'b0, "7/100",   1'b1); drain("7/100");
        issue(32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "-7/2",    1'b1); drain("-7/2");

        // Restart mid-run: only the second operation may report.
        issue(32'd1000, 32'd10, 32'd100, 1'b0, "1000/10_drop", 1'b0);
        repeat (9) @(negedge clk);
        issue(32'd81, 32'd9, 32'd9, 1'b0, "81/9_restart", 1'b1);
        drain("81/9_restart");

        // Start coincident with DONE: both operations report.
        issue(32'd1000, 32'd10, 32'd100, 1'b0, "1000/10", 1'b1);
        repeat (LAT - 1) @(negedge clk);
        issue(32'hFFFFFFAF, 32'd9, 32'hFFFFFFF7, 1'b0, "-81/9_chain", 1'b1);
        drain("-81/9_chain");

        // Result holds across a new start; async reset mid-run drops everything.
        issue(32'd1000, 32'd10, 32'd100, 1'b0, "1000/10_reset", 1'b0);
        repeat (5) @(negedge clk);
        check("result_hold", bus.data_result, 32'hFFFFFFF7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rdy",    W'(bus.data_resultRDY), W'(1'b0));
        check("arst_busy",   W'(bus.busy),           W'(1'b0));
        check("arst_result", bus.data_result,        W'(0));
        check("arst_exc",    W'(bus.data_exception), W'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 6) @(negedge clk);
        check("post_reset_busy", W'(bus.busy), W'(1'b0));

        issue(32'd42, 32'd6, 32'd7, 1'b0, "42/6", 1'b1);
        drain("42/6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
